hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Pipeline sequencer for the 5-stage 64-bit core: owns the IF/ID register's IFID_Write and Flush
//  inputs, plus the PC write enable and the ID/EX bubble select. It decides load-use stalls,
//  taken-branch flushes and data-memory wait freezes. A 3-state FSM handles multi-cycle flush
//  and wait sequencing. Saturating stall/flush counters provide performance telemetry.
// PARAMETERS
//  FLUSH_CYCLES  1   cycles IF/ID Flush stays high after the branch_taken cycle (0..7)
//  CNT_W         16  width of the stall_count / flush_count perf counters
// PORTS
//  clk           in   1      rising-edge clock, single clock domain
//  rst_n         in   1      asynchronous active-low reset
//  ifid_instr    in   32     instruction held in IF/ID; rs1=[19:15], rs2=[24:20]
//  idex_mem_read in   1      instruction in ID/EX is a load
//  idex_rd       in   5      destination register of the ID/EX instruction
//  branch_taken  in   1      branch resolved taken this cycle (1-cycle pulse)
//  mem_busy      in   1      data memory not ready; whole pipeline must freeze
//  pc_write      out  1      PC register load enable
//  ifid_write    out  1      drives IF/ID IFID_Write (0 = hold)
//  ifid_flush    out  1      drives IF/ID Flush (1 = zero PC/instr)
//  idex_bubble   out  1      1 = load zeroed control word into ID/EX
//  stall_count   out  CNT_W  cycles with pc_write=0 while out of reset (saturating)
//  flush_count   out  CNT_W  branch flush events taken (saturating)
// BEHAVIOUR
//  - Asynchronous reset: while rst_n=0, state=RUN, flush_ctr=0, branch_pend=0, and both counters are 0.
//    While rst_n=0 the outputs are pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1.
//  - Outputs are combinational from (state, inputs), so zero-latency hazard response. State and counters are registered.
//  - lu_hazard = idex_mem_read & (idex_rd!=0) & (idex_rd==rs1 | idex_rd==rs2).
//  - Priority each cycle: mem_busy > branch (branch_taken | branch_pend) > FLUSH state > lu_hazard > normal.
//  - State RUN:
//    - mem_busy=1: freeze with all write enables 0 and flush/bubble 0. If branch_taken is also 1,
//      set branch_pend=1. Next state is WAIT.
//    - branch: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, flush_count+1.
//      If FLUSH_CYCLES>0, load flush_ctr=FLUSH_CYCLES and go to FLUSH; otherwise stay in RUN.
//    - lu_hazard: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0. Stay in RUN
//      (the bubble clears idex_mem_read next cycle, so the stall lasts exactly 1 cycle).
//    - normal: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
//  - State FLUSH: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1, lu_hazard ignored, flush_ctr-1.
//    - Go to RUN when flush_ctr==1.
//    - A new branch_taken reloads flush_ctr=FLUSH_CYCLES and increments flush_count.
//    - mem_busy=1 freezes the sequence: flush_ctr holds, go to WAIT, and FLUSH is resumed on exit.
//  - State WAIT: freeze outputs (all 0) while mem_busy=1.
//    - branch_taken during WAIT sets branch_pend; multiple pulses collapse into one.
//    - When mem_busy=0: if branch_pend=1, perform the branch action above and clear branch_pend.
//      Otherwise return to the prior state (RUN or FLUSH, held in a ret_flush bit) and apply its rules this cycle.
//  - Counters saturate at 2^CNT_W-1 and never wrap.
//    - stall_count increments on every cycle with rst_n=1 and pc_write=0.
//  - FLUSH_CYCLES=0: FLUSH state is never entered and the branch flush lasts a single cycle.
//  - Reset mid-FLUSH or mid-WAIT discards flush_ctr and branch_pend immediately (asynchronous).
// TESTING
//  1. Load-use: idex_mem_read=1, idex_rd=5, ifid_instr rs1=5 -> pc_write=0, ifid_write=0, idex_bubble=1
//     for exactly 1 cycle; stall_count=1. Repeat with idex_rd=0 -> no stall.
//  2. Branch with FLUSH_CYCLES=1: branch_taken pulse -> ifid_flush=1 for 2 cycles, flush_count=1, pc_write stays 1.
//     A load-use hazard in the second cycle is ignored.
//  3. mem_busy high for 4 cycles with a branch_taken pulse in cycle 2 -> all enables 0 for 4 cycles, stall_count=4.
//     On the cycle after mem_busy falls: ifid_flush=1, idex_bubble=1, flush_count=1.
//  4. Simultaneous branch_taken and lu_hazard in RUN -> branch wins: ifid_flush=1, pc_write=1, no stall counted.
//  5. rst_n asserted low mid-FLUSH (flush_ctr=1) -> outputs immediately 0/0/1/1 and counters 0.
//     After release: RUN with normal enables.
//  6. CNT_W=4: 20 consecutive mem_busy cycles -> stall_count saturates at 15 and holds.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: pipeline sequencer for the 5-stage core.
// Decides load-use stalls, taken-branch flushes and data-memory freezes.
// It drives the PC write enable, IF/ID write/flush and the ID/EX bubble select.
// Saturating stall/flush counters provide performance telemetry.
//
// Handshake/control contract: every output is combinational from (state,
// inputs), so a hazard is answered in the same cycle it appears. While rst_n is
// low, the outputs are forced to the safe pattern pc_write=0, ifid_write=0,
// ifid_flush=1, idex_bubble=1.
module hazard_ctrl_unit #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ifid_instr,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

    state_t     state, state_n;
    logic [2:0] flush_ctr, flush_ctr_n;
    logic       branch_pend, branch_pend_n;
    logic       ret_flush, ret_flush_n;
    logic       flush_inc;
    logic       lu_hazard;
    logic       in_flush;
    logic       pc_w, ifid_w, ifid_f, idex_b;

    assign lu_hazard = idex_mem_read && (idex_rd != 5'd0) &&
                       ((idex_rd == ifid_instr[19:15]) || (idex_rd == ifid_instr[24:20]));

    // FLUSH rules apply in FLUSH, and when leaving WAIT back into an interrupted flush.
    assign in_flush = (state == ST_FLUSH) || ((state == ST_WAIT) && ret_flush);

    assign dbg_state = state;

    // Next-state and control decode, priority: mem_busy > branch > flush > load-use > normal.
    always_comb begin
        state_n       = ST_RUN;
        flush_ctr_n   = flush_ctr;
        branch_pend_n = branch_pend;
        ret_flush_n   = ret_flush;
        flush_inc     = 1'b0;
        pc_w          = 1'b1;
        ifid_w        = 1'b1;
        ifid_f        = 1'b0;
        idex_b        = 1'b0;

        if (mem_busy) begin
            // Full freeze; a branch seen now is remembered and replayed on exit.
            pc_w          = 1'b0;
            ifid_w        = 1'b0;
            branch_pend_n = branch_pend | branch_taken;
            state_n       = ST_WAIT;
            if (state != ST_WAIT) begin
                ret_flush_n = (state == ST_FLUSH);
            end
        end else if (branch_taken || branch_pend) begin
            ifid_f        = 1'b1;
            idex_b        = 1'b1;
            flush_inc     = 1'b1;
            branch_pend_n = 1'b0;
            if (FLUSH_CYCLES > 0) begin
                flush_ctr_n = FC;
                state_n     = ST_FLUSH;
            end
        end else if (in_flush) begin
            // Load-use is irrelevant here: the instruction in IF/ID is being squashed.
            ifid_f      = 1'b1;
            idex_b      = 1'b1;
            flush_ctr_n = flush_ctr - 3'd1;
            state_n     = (flush_ctr == 3'd1) ? ST_RUN : ST_FLUSH;
        end else if (lu_hazard) begin
            // One-cycle stall: the bubble clears idex_mem_read on the next cycle.
            pc_w   = 1'b0;
            ifid_w = 1'b0;
            idex_b = 1'b1;
        end
    end

    // Outputs, overridden by the safe pattern while reset is held.
    always_comb begin
        pc_write    = pc_w   & rst_n;
        ifid_write  = ifid_w & rst_n;
        ifid_flush  = ifid_f | ~rst_n;
        idex_bubble = idex_b | ~rst_n;
    end

    // FSM state and sequencing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            flush_ctr   <= 3'd0;
            branch_pend <= 1'b0;
            ret_flush   <= 1'b0;
        end else begin
            state       <= state_n;
            flush_ctr   <= flush_ctr_n;
            branch_pend <= branch_pend_n;
            ret_flush   <= ret_flush_n;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!pc_w && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
            if (flush_inc && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances share stimulus.
// dut_a uses FLUSH_CYCLES=1 and CNT_W=16; dut_b uses FLUSH_CYCLES=0 and CNT_W=4.
// Expected control patterns {pc_write, ifid_write, ifid_flush, idex_bubble} of
// both instances are queued when a cycle is driven and popped by a monitor at
// the falling edge.
module tb_hazard_ctrl_unit;

    localparam logic [3:0] NORM  = 4'b1100;
    localparam logic [3:0] STALL = 4'b0001;
    localparam logic [3:0] FL    = 4'b1111;
    localparam logic [3:0] FRZ   = 4'b0000;
    localparam logic [3:0] RSTO  = 4'b0011;

    localparam logic [31:0] I_RS1_5 = 32'h0002_8000;  // rs1=5
    localparam logic [31:0] I_RS2_7 = 32'h0070_0000;  // rs2=7
    localparam logic [31:0] I_ZERO  = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] ifid_instr;
    logic        idex_mem_read;
    logic [4:0]  idex_rd;
    logic        branch_taken;
    logic        mem_busy;

    logic        a_pc, a_ifw, a_fl, a_bub;
    logic        b_pc, b_ifw, b_fl, b_bub;
    logic [15:0] a_stall, a_flush;
    logic [3:0]  b_stall, b_flush;
    logic [1:0]  a_state, b_state;

    logic [7:0]  exp_q[$];
    string       tag_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    hazard_ctrl_unit #(.FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .ifid_instr(ifid_instr), .idex_mem_read(idex_mem_read),
        .idex_rd(idex_rd), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(a_pc), .ifid_write(a_ifw), .ifid_flush(a_fl), .idex_bubble(a_bub),
        .stall_count(a_stall), .flush_count(a_flush), .dbg_state(a_state)
    );

    hazard_ctrl_unit #(.FLUSH_CYCLES(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .ifid_instr(ifid_instr), .idex_mem_read(idex_mem_read),
        .idex_rd(idex_rd), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(b_pc), .ifid_write(b_ifw), .ifid_flush(b_fl), .idex_bubble(b_bub),
        .stall_count(b_stall), .flush_count(b_flush), .dbg_state(b_state)
    );

    // Clock / reset block.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, queue the expected
    // outputs of both instances, and advance to just after the next rising edge.
    task automatic step(input string tag, input logic bt, input logic mb, input logic mr,
                        input logic [4:0] rd, input logic [31:0] instr,
                        input logic [3:0] exp_a, input logic [3:0] exp_b);
        branch_taken  = bt;
        mem_busy      = mb;
        idex_mem_read = mr;
        idex_rd       = rd;
        ifid_instr    = instr;
        exp_q.push_back({exp_a, exp_b});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [3:0] exp_a, input logic [3:0] exp_b);
        step(tag, 1'b0, 1'b0, 1'b0, 5'd0, I_ZERO, exp_a, exp_b);
    endtask

    task automatic check_cnt(input string tag, input int sa, input int sb, input int fa, input int fb);
        check({tag, "_stall_a"}, 32'(a_stall), 32'(sa));
        check({tag, "_stall_b"}, 32'(b_stall), 32'(sb));
        check({tag, "_flush_a"}, 32'(a_flush), 32'(fa));
        check({tag, "_flush_b"}, 32'(b_flush), 32'(fb));
    endtask

    // Scoreboard monitor: compare both instances mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check(tag_q.pop_front(), 32'({a_pc, a_ifw, a_fl, a_bub, b_pc, b_ifw, b_fl, b_bub}),
                  32'(exp_q.pop_front()));
        end
    end

    initial begin
        rst_n         = 1'b0;
        branch_taken  = 1'b0;
        mem_busy      = 1'b0;
        idex_mem_read = 1'b0;
        idex_rd       = 5'd0;
        ifid_instr    = I_ZERO;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_a", 32'({a_pc, a_ifw, a_fl, a_bub}), 32'(RSTO));
        check("reset_out_b", 32'({b_pc, b_ifw, b_fl, b_bub}), 32'(RSTO));
        check_cnt("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

        // Load-use on rs1 and rs2, rd=0 and non-matching rd.
        step("lu_rs1", 1'b0, 1'b0, 1'b1, 5'd5, I_RS1_5, STALL, STALL);
        step("lu_after", 1'b0, 1'b0, 1'b0, 5'd5, I_RS1_5, NORM, NORM);
        check_cnt("lu1", 1, 1, 0, 0);
        step("lu_rd0", 1'b0, 1'b0, 1'b1, 5'd0, I_ZERO, NORM, NORM);
        step("lu_rs2", 1'b0, 1'b0, 1'b1, 5'd7, I_RS2_7, STALL, STALL);
        step("lu_nomatch", 1'b0, 1'b0, 1'b1, 5'd6, I_RS1_5, NORM, NORM);
        check_cnt("lu2", 2, 2, 0, 0);

        // Branch: two flush cycles with FLUSH_CYCLES=1, one with 0; load-use ignored in FLUSH.
        step("br", 1'b1, 1'b0, 1'b0, 5'd0, I_ZERO, FL, FL);
        step("br_lu", 1'b0, 1'b0, 1'b1, 5'd5, I_RS1_5, FL, STALL);
        idle("br_done", NORM, NORM);
        check_cnt("br", 2, 3, 1, 1);

        // Branch and load-use together: branch wins.
        step("br_and_lu", 1'b1, 1'b0, 1'b1, 5'd5, I_RS1_5, FL, FL);
        idle("br_and_lu_2", FL, NORM);
        idle("br_and_lu_3", NORM, NORM);
        check_cnt("br_lu", 2, 3, 2, 2);

        // mem_busy for 4 cycles with a branch pulse in cycle 2, replayed on exit.
        step("mb1", 1'b0, 1'b1, 1'b0, 5'd0, I_ZERO, FRZ, FRZ);
        step("mb2", 1'b1, 1'b1, 1'b0, 5'd0, I_ZERO, FRZ, FRZ);
        step("mb3", 1'b0, 1'b1, 1'b0, 5'd0, I_ZERO, FRZ, FRZ);
        step("mb4", 1'b0, 1'b1, 1'b0, 5'd0, I_ZERO, FRZ, FRZ);
        check_cnt("mb", 6, 7, 2, 2);
        idle("mb_exit", FL, FL);
        idle("mb_exit2", FL, NORM);
        idle("mb_exit3", NORM, NORM);
        check_cnt("mb_exit", 6, 7, 3, 3);

        // Freeze in the middle of a flush: the flush resumes after the freeze.
        step("fz_br", 1'b1, 1'b0, 1'b0, 5'd0, I_ZERO, FL, FL);
        step("fz_busy", 1'b0, 1'b1, 1'b0, 5'd0, I_ZERO, FRZ, FRZ);
        idle("fz_resume", FL, NORM);
        idle("fz_done", NORM, NORM);

        // A second branch inside FLUSH reloads the flush counter.
        step("rl_br1", 1'b1, 1'b0, 1'b0, 5'd0, I_ZERO, FL, FL);
        step("rl_br2", 1'b1, 1'b0, 1'b0, 5'd0, I_ZERO, FL, FL);
        idle("rl_tail", FL, NORM);
        idle("rl_done", NORM, NORM);

        // Several branch pulses during WAIT collapse into one flush event.
        step("cl1", 1'b1, 1'b1, 1'b0, 5'd0, I_ZERO, FRZ, FRZ);
        step("cl2", 1'b1, 1'b1, 1'b0, 5'd0, I_ZERO, FRZ, FRZ);
        step("cl3", 1'b0, 1'b1, 1'b0, 5'd0, I_ZERO, FRZ, FRZ);
        idle("cl_exit", FL, FL);
        idle("cl_exit2", FL, NORM);
        idle("cl_done", NORM, NORM);
        check_cnt("cl", 10, 11, 7, 7);

        // 20 freeze cycles: the 4-bit stall counter saturates at 15 and holds.
        for (int i = 0; i < 20; i++) begin
            step("sat", 1'b0, 1'b1, 1'b0, 5'd0, I_ZERO, FRZ, FRZ);
            if (i == 3) check("sat_reach_b", 32'(b_stall), 32'd15);
        end
        check_cnt("sat", 30, 15, 7, 7);
        idle("sat_exit", NORM, NORM);

        // Reset in the middle of a flush.
        step("rs_br", 1'b1, 1'b0, 1'b0, 5'd0, I_ZERO, FL, FL);
        check("rs_in_flush", 32'(a_state), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rs_out_a", 32'({a_pc, a_ifw, a_fl, a_bub}), 32'(RSTO));
        check("rs_out_b", 32'({b_pc, b_ifw, b_fl, b_bub}), 32'(RSTO));
        check_cnt("rs", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("rs_lu", 1'b0, 1'b0, 1'b1, 5'd5, I_RS1_5, STALL, STALL);
        idle("rs_norm", NORM, NORM);
        check_cnt("rs_after", 1, 1, 0, 0);

        // Random load-use traffic; expectations from the stated hazard equation.
        for (int i = 0; i < 40; i++) begin
            logic        mr;
            logic [4:0]  rd, r1, r2;
            logic [3:0]  e;
            mr = 1'($urandom_range(0, 1));
            rd = 5'($urandom_range(0, 3));
            r1 = 5'($urandom_range(0, 3));
            r2 = 5'($urandom_range(0, 3));
            e  = (mr && rd != 5'd0 && (rd == r1 || rd == r2)) ? STALL : NORM;
            step("rand_lu", 1'b0, 1'b0, mr, rd, {7'd0, r2, r1, 15'd0}, e, e);
            idle("rand_gap", NORM, NORM);
        end

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
